// File: rtl/tag_lookup_pkg.sv
// Shared types and helpers for the tag lookup/allocate stage.
package tag_lookup_pkg;

   localparam int TL_WAY_NUM   = 4;
   localparam int TL_SET_WIDTH = 6;
   localparam int TL_TAG_WIDTH = 20;

   typedef struct packed {
      logic                    hit;
      logic [TL_WAY_NUM-1:0]   way;
      logic [TL_SET_WIDTH-1:0] set;
      logic [TL_TAG_WIDTH-1:0] tag;
      logic                    evict_valid;
      logic [TL_TAG_WIDTH-1:0] evict_tag;
   } tag_lookup_rsp_t;

   // Isolates the lowest set bit; all-zero input gives all-zero output.
   function automatic logic [TL_WAY_NUM-1:0] lowest_one(input logic [TL_WAY_NUM-1:0] vec);
      return vec & (~vec + TL_WAY_NUM'(1));
   endfunction

endpackage

// File: rtl/tag_lookup_rsp_fifo.sv
// Two-entry in-order response buffer; count feeds the request credit check.
module tag_lookup_rsp_fifo
   import tag_lookup_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            push_valid,
   input  tag_lookup_rsp_t push_data,
   output logic            pop_valid,
   input  logic            pop_ready,
   output tag_lookup_rsp_t pop_data,
   output logic [1:0]      count
);

   tag_lookup_rsp_t mem_q [2];
   logic            wr_ptr_q;
   logic            rd_ptr_q;
   logic [1:0]      count_q;
   logic            pop;

   assign pop       = pop_valid && pop_ready;
   assign pop_valid = (count_q != 2'd0);
   assign pop_data  = mem_q[rd_ptr_q];
   assign count     = count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         // Push into a full FIFO is only legal alongside a pop of the head slot.
         if (push_valid) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop)
            rd_ptr_q <= ~rd_ptr_q;
         count_q <= count_q + 2'(push_valid) - 2'(pop);
      end
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
      (push_valid && count_q == 2'd2) |-> pop);

endmodule

// File: rtl/tag_lookup.sv
// Lookup/allocate stage in front of tag_array: compare, victim select, allocation
// write and buffered response. Valid bits live in flops so flush is single-cycle.
module tag_lookup
   import tag_lookup_pkg::*;
#(
   parameter int WAY_NUM   = TL_WAY_NUM,
   parameter int SET_WIDTH = TL_SET_WIDTH,
   parameter int TAG_WIDTH = TL_TAG_WIDTH
)(
   input  logic                               clk,
   input  logic                               rst_n,
   input  logic                               req_valid,
   output logic                               req_ready,
   input  logic [SET_WIDTH-1:0]               req_set,
   input  logic [TAG_WIDTH-1:0]               req_tag,
   output logic                               tag_read_valid,
   input  logic                               tag_read_ready,
   output logic [SET_WIDTH-1:0]               tag_read_set,
   input  logic [WAY_NUM-1:0][TAG_WIDTH-1:0]  tag_read_rsp,
   output logic                               tag_write_valid,
   input  logic                               tag_write_ready,
   output logic [SET_WIDTH-1:0]               tag_write_set,
   output logic [WAY_NUM-1:0]                 tag_write_way_en,
   output logic [TAG_WIDTH-1:0]               tag_write_data,
   input  logic                               flush_valid,
   output logic                               flush_ready,
   output logic                               rsp_valid,
   input  logic                               rsp_ready,
   output logic                               rsp_hit,
   output logic [WAY_NUM-1:0]                 rsp_way,
   output logic [SET_WIDTH-1:0]               rsp_set,
   output logic [TAG_WIDTH-1:0]               rsp_tag,
   output logic                               rsp_evict_valid,
   output logic [TAG_WIDTH-1:0]               rsp_evict_tag
);

   localparam int RR_W    = $clog2(WAY_NUM);
   localparam int SET_NUM = 2**SET_WIDTH;

   logic                 s1_valid;
   logic [SET_WIDTH-1:0] s1_set;
   logic [TAG_WIDTH-1:0] s1_tag;
   logic [WAY_NUM-1:0]   valid_q [SET_NUM];
   logic [RR_W-1:0]      rr_q;

   logic [WAY_NUM-1:0]   set_valid;
   logic [WAY_NUM-1:0]   hit_vec;
   logic [WAY_NUM-1:0]   victim;
   logic                 hit;
   logic                 set_full;
   logic                 miss;
   logic                 write_fire;
   logic [TAG_WIDTH-1:0] evict_tag;

   logic                 req_fire;
   logic                 flush_fire;
   logic                 pop;
   logic [2:0]           credit_used;
   logic [1:0]           fifo_count;
   logic                 fifo_push;
   tag_lookup_rsp_t      push_data;
   tag_lookup_rsp_t      head;

   // S0: a slot is reserved for the request already in S1 so the FIFO cannot overflow.
   assign pop            = rsp_valid && rsp_ready;
   assign credit_used    = {1'b0, fifo_count} + 3'(s1_valid) - 3'(pop);
   assign req_ready      = rst_n && tag_read_ready && !flush_valid && (credit_used < 3'd2);
   assign tag_read_valid = req_valid && req_ready;
   assign tag_read_set   = req_set;
   assign req_fire       = tag_read_valid;

   assign flush_ready = rst_n && !s1_valid;
   assign flush_fire  = flush_valid && flush_ready;

   always_comb begin
      set_valid = valid_q[s1_set];
      for (int w = 0; w < WAY_NUM; w++)
         hit_vec[w] = set_valid[w] && (tag_read_rsp[w] == s1_tag);
   end

   assign hit      = |hit_vec;
   assign set_full = &set_valid;
   assign miss     = s1_valid && !hit;
   assign victim   = set_full ? (WAY_NUM'(1) << rr_q) : lowest_one(~set_valid);

   always_comb begin
      evict_tag = '0;
      for (int w = 0; w < WAY_NUM; w++)
         if (victim[w])
            evict_tag = tag_read_rsp[w];
   end

   assign tag_write_valid  = rst_n && miss;
   assign tag_write_set    = s1_set;
   assign tag_write_way_en = victim;
   assign tag_write_data   = s1_tag;
   assign write_fire       = tag_write_valid && tag_write_ready;

   assign fifo_push             = rst_n && s1_valid;
   assign push_data.hit         = hit;
   assign push_data.way         = hit ? lowest_one(hit_vec) : victim;
   assign push_data.set         = s1_set;
   assign push_data.tag         = s1_tag;
   assign push_data.evict_valid = !hit && set_full;
   assign push_data.evict_tag   = (!hit && set_full) ? evict_tag : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_set   <= '0;
         s1_tag   <= '0;
         rr_q     <= '0;
         for (int s = 0; s < SET_NUM; s++)
            valid_q[s] <= '0;
      end else begin
         s1_valid <= req_fire;
         if (req_fire) begin
            s1_set <= req_set;
            s1_tag <= req_tag;
         end
         if (flush_fire) begin
            for (int s = 0; s < SET_NUM; s++)
               valid_q[s] <= '0;
         end else if (write_fire) begin
            valid_q[s1_set] <= valid_q[s1_set] | victim;
         end
         // Round-robin only moves when a valid way is actually displaced.
         if (write_fire && set_full)
            rr_q <= (rr_q == RR_W'(WAY_NUM - 1)) ? '0 : rr_q + RR_W'(1);
      end
   end

   tag_lookup_rsp_fifo u_rsp_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push_valid (fifo_push),
      .push_data  (push_data),
      .pop_valid  (rsp_valid),
      .pop_ready  (rsp_ready),
      .pop_data   (head),
      .count      (fifo_count)
   );

   assign rsp_hit         = head.hit;
   assign rsp_way         = head.way;
   assign rsp_set         = head.set;
   assign rsp_tag         = head.tag;
   assign rsp_evict_valid = head.evict_valid;
   assign rsp_evict_tag   = head.evict_tag;

   a_one_hit: assert property (@(posedge clk) disable iff (!rst_n)
      s1_valid |-> $onehot0(hit_vec));

   a_write_taken: assert property (@(posedge clk) disable iff (!rst_n)
      tag_write_valid |-> tag_write_ready);

endmodule

// File: tb/tb_tag_lookup.sv
// Bench for tag_lookup: tag_array behavioural model, reference allocation model
// feeding a response scoreboard, plus per-scenario cycle checks.
module tb_tag_lookup;
   import tag_lookup_pkg::*;

   localparam int WN = 4;
   localparam int SW = 6;
   localparam int TW = 20;

   localparam logic [TW-1:0] TAG_A = 20'h12345;
   localparam logic [TW-1:0] TAG_B = 20'h0BEEF;
   localparam logic [TW-1:0] TAG_C = 20'h0CAFE;
   localparam logic [TW-1:0] TAG_D = 20'h0D00D;
   localparam logic [TW-1:0] TAG_E = 20'hE0E0E;
   localparam logic [TW-1:0] TAG_F = 20'hF1F1F;
   localparam logic [TW-1:0] TAG_G = 20'h77777;

   logic                    clk = 1'b0;
   logic                    rst_n;
   logic                    req_valid;
   logic                    req_ready;
   logic [SW-1:0]           req_set;
   logic [TW-1:0]           req_tag;
   logic                    tag_read_valid;
   logic                    tag_read_ready;
   logic [SW-1:0]           tag_read_set;
   logic [WN-1:0][TW-1:0]   tag_read_rsp;
   logic                    tag_write_valid;
   logic                    tag_write_ready;
   logic [SW-1:0]           tag_write_set;
   logic [WN-1:0]           tag_write_way_en;
   logic [TW-1:0]           tag_write_data;
   logic                    flush_valid;
   logic                    flush_ready;
   logic                    rsp_valid;
   logic                    rsp_ready;
   logic                    rsp_hit;
   logic [WN-1:0]           rsp_way;
   logic [SW-1:0]           rsp_set;
   logic [TW-1:0]           rsp_tag;
   logic                    rsp_evict_valid;
   logic [TW-1:0]           rsp_evict_tag;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   tag_lookup dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_set          (req_set),
      .req_tag          (req_tag),
      .tag_read_valid   (tag_read_valid),
      .tag_read_ready   (tag_read_ready),
      .tag_read_set     (tag_read_set),
      .tag_read_rsp     (tag_read_rsp),
      .tag_write_valid  (tag_write_valid),
      .tag_write_ready  (tag_write_ready),
      .tag_write_set    (tag_write_set),
      .tag_write_way_en (tag_write_way_en),
      .tag_write_data   (tag_write_data),
      .flush_valid      (flush_valid),
      .flush_ready      (flush_ready),
      .rsp_valid        (rsp_valid),
      .rsp_ready        (rsp_ready),
      .rsp_hit          (rsp_hit),
      .rsp_way          (rsp_way),
      .rsp_set          (rsp_set),
      .rsp_tag          (rsp_tag),
      .rsp_evict_valid  (rsp_evict_valid),
      .rsp_evict_tag    (rsp_evict_tag)
   );

   // tag_array: read data one cycle after the read, reads blocked while writing
   logic [TW-1:0] sram [2**SW][WN] = '{default: '0};

   assign tag_read_ready  = !tag_write_valid;
   assign tag_write_ready = 1'b1;

   always @(posedge clk) begin
      if (tag_read_valid)
         for (int w = 0; w < WN; w++)
            tag_read_rsp[w] <= sram[tag_read_set][w];
      if (tag_write_valid)
         for (int w = 0; w < WN; w++)
            if (tag_write_way_en[w])
               sram[tag_write_set][w] <= tag_write_data;
   end

   // reference model of valid bits, tags and round-robin pointer
   logic [WN-1:0]   m_valid [2**SW];
   logic [TW-1:0]   m_tag   [2**SW][WN] = '{default: '0};
   int              m_rr = 0;
   tag_lookup_rsp_t exp_q [$];
   int              pop_cyc [$];

   task automatic model_accept(input logic [SW-1:0] s, input logic [TW-1:0] t);
      tag_lookup_rsp_t e;
      logic            found;
      e       = '0;
      e.set   = s;
      e.tag   = t;
      found   = 1'b0;
      for (int w = 0; w < WN; w++)
         if (!found && m_valid[s][w] && m_tag[s][w] == t) begin
            found = 1'b1;
            e.hit = 1'b1;
            e.way = WN'(1) << w;
         end
      if (!found) begin
         for (int w = 0; w < WN; w++)
            if (!found && !m_valid[s][w]) begin
               found = 1'b1;
               e.way = WN'(1) << w;
            end
         if (!found) begin
            e.way         = WN'(1) << m_rr;
            e.evict_valid = 1'b1;
            e.evict_tag   = m_tag[s][m_rr];
            m_rr          = (m_rr + 1) % WN;
         end
         for (int w = 0; w < WN; w++)
            if (e.way[w]) begin
               m_valid[s][w] = 1'b1;
               m_tag[s][w]   = t;
            end
      end
      exp_q.push_back(e);
   endtask

   always @(negedge clk) begin : monitor
      tag_lookup_rsp_t e;
      if (!rst_n) begin
         for (int s = 0; s < 2**SW; s++)
            m_valid[s] = '0;
         m_rr = 0;
         exp_q.delete();
      end else begin
         if (rsp_valid && rsp_ready) begin
            pop_cyc.push_back(cyc);
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL rsp_unexpected got set=%0d tag=%0h, want no response", rsp_set, rsp_tag);
            end else begin
               e = exp_q.pop_front();
               if ({rsp_hit, rsp_way, rsp_set, rsp_tag, rsp_evict_valid} !==
                   {e.hit, e.way, e.set, e.tag, e.evict_valid}) begin
                  bad++;
                  $display("FAIL rsp_fields got hit=%0b way=%b set=%0d tag=%0h ev=%0b want hit=%0b way=%b set=%0d tag=%0h ev=%0b",
                           rsp_hit, rsp_way, rsp_set, rsp_tag, rsp_evict_valid,
                           e.hit, e.way, e.set, e.tag, e.evict_valid);
               end
               if (e.evict_valid) begin
                  total++;
                  if (rsp_evict_tag !== e.evict_tag) begin
                     bad++;
                     $display("FAIL rsp_evict_tag got=%0h want=%0h", rsp_evict_tag, e.evict_tag);
                  end
               end
            end
         end
         if (flush_valid && flush_ready)
            for (int s = 0; s < 2**SW; s++)
               m_valid[s] = '0;
         if (req_valid && req_ready)
            model_accept(req_set, req_tag);
      end
   end

   // Caller sits at posedge+1; returns at posedge+1 of the cycle after accept.
   task automatic send(input logic [SW-1:0] s, input logic [TW-1:0] t, output int acc_cyc);
      int n = 0;
      req_valid = 1'b1;
      req_set   = s;
      req_tag   = t;
      @(negedge clk);
      while (!req_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      acc_cyc = cyc;
      total++;
      if (!req_ready) begin
         bad++;
         $display("FAIL send_accept set=%0d tag=%0h got req_ready=0 want 1 within 50 cycles", s, t);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL drain got pending=%0d want 0", exp_q.size());
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n       = 1'b0;
      req_valid   = 1'b1;
      req_set     = '0;
      req_tag     = '0;
      flush_valid = 1'b0;
      rsp_ready   = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      total++;
      if ({rsp_valid, tag_read_valid, tag_write_valid, req_ready} !== 4'b0000) begin
         bad++;
         $display("FAIL reset_outputs got rv/trv/twv/rr=%b want 0000",
                  {rsp_valid, tag_read_valid, tag_write_valid, req_ready});
      end
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL post_reset_rsp_valid got=%b want 0", rsp_valid);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_cold_miss();
      int t0;
      req_valid = 1'b1;
      req_set   = 6'd3;
      req_tag   = TAG_A;
      @(negedge clk);
      t0 = cyc;
      total++;
      if ({req_ready, tag_read_valid, tag_read_set} !== {1'b1, 1'b1, 6'd3}) begin
         bad++;
         $display("FAIL cold_read got ready=%b rv=%b set=%0d want 1 1 3", req_ready, tag_read_valid, tag_read_set);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      total++;
      if ({tag_write_valid, tag_write_set, tag_write_way_en, tag_write_data, req_ready} !==
          {1'b1, 6'd3, 4'b0001, TAG_A, 1'b0}) begin
         bad++;
         $display("FAIL cold_write got wv=%b set=%0d way=%b data=%0h rdy=%b want 1 3 0001 12345 0",
                  tag_write_valid, tag_write_set, tag_write_way_en, tag_write_data, req_ready);
      end
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b1 || cyc != t0 + 2) begin
         bad++;
         $display("FAIL cold_latency got rsp_valid=%b at +%0d want 1 at +2", rsp_valid, cyc - t0);
      end
      drain();
   endtask

   task automatic test_rehit();
      int a;
      send(6'd3, TAG_A, a);
      @(negedge clk);
      total++;
      if (tag_write_valid !== 1'b0) begin
         bad++;
         $display("FAIL rehit_no_write got wv=%b want 0", tag_write_valid);
      end
      drain();
   endtask

   task automatic test_full_set();
      int a;
      send(6'd3, TAG_B, a);
      send(6'd3, TAG_C, a);
      send(6'd3, TAG_D, a);
      drain();
      send(6'd3, TAG_E, a);
      @(negedge clk);
      total++;
      if ({tag_write_valid, tag_write_way_en} !== {1'b1, 4'b0001}) begin
         bad++;
         $display("FAIL full_victim_e got wv=%b way=%b want 1 0001", tag_write_valid, tag_write_way_en);
      end
      @(posedge clk);
      #1;
      send(6'd3, TAG_F, a);
      @(negedge clk);
      total++;
      if ({tag_write_valid, tag_write_way_en} !== {1'b1, 4'b0010}) begin
         bad++;
         $display("FAIL full_victim_f got wv=%b way=%b want 1 0010", tag_write_valid, tag_write_way_en);
      end
      drain();
   endtask

   task automatic test_back_to_back();
      logic [TW-1:0] tags [4];
      int            acc [4];
      tags = '{TAG_E, TAG_F, TAG_C, TAG_D};
      pop_cyc.delete();
      for (int i = 0; i < 4; i++)
         send(6'd3, tags[i], acc[i]);
      drain();
      total++;
      if (pop_cyc.size() != 4) begin
         bad++;
         $display("FAIL b2b_count got=%0d want 4", pop_cyc.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (acc[i] != acc[0] + i || pop_cyc[i] != acc[0] + 2 + i) begin
               bad++;
               $display("FAIL b2b_timing idx=%0d got acc=+%0d rsp=+%0d want acc=+%0d rsp=+%0d",
                        i, acc[i] - acc[0], pop_cyc[i] - acc[0], i, i + 2);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      pop_cyc.delete();
      rsp_ready = 1'b0;
      fork
         begin
            int a;
            send(6'd3, TAG_C, a);
            send(6'd3, TAG_D, a);
            send(6'd3, TAG_E, a);
            send(6'd3, TAG_F, a);
         end
         begin
            repeat (5) @(negedge clk);
            total++;
            if ({req_valid, req_ready, rsp_valid} !== 3'b101) begin
               bad++;
               $display("FAIL bp_stall got valid/ready/rsp_valid=%b want 101", {req_valid, req_ready, rsp_valid});
            end
            @(posedge clk);
            #1;
            rsp_ready = 1'b1;
         end
      join
      drain();
      total++;
      if (pop_cyc.size() != 4) begin
         bad++;
         $display("FAIL bp_count got=%0d want 4", pop_cyc.size());
      end
   endtask

   task automatic test_flush();
      int a;
      flush_valid = 1'b1;
      @(negedge clk);
      total++;
      if ({flush_ready, req_ready} !== 2'b10) begin
         bad++;
         $display("FAIL flush_accept got fr/rr=%b want 10", {flush_ready, req_ready});
      end
      @(posedge clk);
      #1;
      flush_valid = 1'b0;
      send(6'd3, TAG_A, a);
      @(negedge clk);
      total++;
      if ({tag_write_valid, tag_write_way_en} !== {1'b1, 4'b0001}) begin
         bad++;
         $display("FAIL flush_realloc got wv=%b way=%b want 1 0001", tag_write_valid, tag_write_way_en);
      end
      drain();
   endtask

   task automatic test_reset_midflight();
      int a;
      send(6'd3, TAG_G, a);
      rst_n = 1'b0;
      @(negedge clk);
      total++;
      if (tag_write_valid !== 1'b0) begin
         bad++;
         $display("FAIL midreset_write got wv=%b want 0", tag_write_valid);
      end
      @(posedge clk);
      #1;
      @(negedge clk);
      total++;
      if (rsp_valid !== 1'b0) begin
         bad++;
         $display("FAIL midreset_rsp got rsp_valid=%b want 0", rsp_valid);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      send(6'd3, TAG_A, a);
      @(negedge clk);
      total++;
      if ({tag_write_valid, tag_write_way_en} !== {1'b1, 4'b0001}) begin
         bad++;
         $display("FAIL midreset_miss got wv=%b way=%b want 1 0001", tag_write_valid, tag_write_way_en);
      end
      drain();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog got time=%0t want finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_cold_miss();
      test_rehit();
      test_full_set();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
